l1_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `l1` cache instance between `NUM_REQ` requesters (e.g. fetch and load/store ports). It accepts one request per L1 two-cycle slot and drives the L1 address, write-enable and data pins in step with the L1's internal phase. It returns the registered hit/miss and read data to the issuing requester tagged with its ID. It sits between the requester ports and `l1`; `l1.rst` is tied to `~rst_n` at the top level.

---
 rtl/l1_arbiter.sv | 153 +++++++++++++++
 tb/tb_l1_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_arbiter.sv
// Round-robin arbiter/sequencer sharing one two-phase l1 cache between NUM_REQ requesters.
// Define L1_ARB_STATS_EN to add saturating read hit/miss counters (stat_rd_hits/stat_rd_misses).
module l1_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int WORD_SIZE = 32,
   parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_wr,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_addr,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         l1_wr_en,
   output logic [WORD_SIZE-1:0]         l1_addr,
   output logic [WORD_SIZE-1:0]         l1_data,
   input  logic [WORD_SIZE-1:0]         l1_data_out,
   input  logic                         l1_hit,
   output logic                         rsp_valid,
   output logic [ID_W-1:0]              rsp_id,
   output logic                         rsp_wr,
   output logic                         rsp_hit,
   output logic [WORD_SIZE-1:0]         rsp_data
`ifdef L1_ARB_STATS_EN
   ,
   output logic [15:0]                  stat_rd_hits,
   output logic [15:0]                  stat_rd_misses
`endif
);

   // state | meaning
   // IDLE  | no issued op, no pending response (l1 does a discarded read of address 0)
   // ADDR  | iss_valid, phase 0: l1 latches tag/index from l1_addr
   // OP    | iss_valid, phase 1: l1 samples wr_en/data; next request may be accepted
   // RESP  | pend, phase 0: l1 outputs valid, captured into rsp_* at the end of the cycle
   localparam logic [0:0]      PH_ADDR = 1'b0;
   localparam logic [0:0]      PH_OP   = 1'b1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
   localparam logic [ID_W-1:0] ID_ONE  = ID_W'(1);

   logic [0:0]           phase;
   logic [ID_W-1:0]      last_grant;
   logic                 iss_valid;
   logic                 iss_wr;
   logic [WORD_SIZE-1:0] iss_addr;
   logic [WORD_SIZE-1:0] iss_data;
   logic [ID_W-1:0]      iss_id;
   logic                 pend;
   logic                 pend_wr;
   logic [ID_W-1:0]      pend_id;

   logic                 gnt_found;
   logic [ID_W-1:0]      gnt_id;
   logic [ID_W-1:0]      cand;
   logic                 accept;
   logic [WORD_SIZE-1:0] addr_arr [NUM_REQ];
   logic [WORD_SIZE-1:0] data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[g*WORD_SIZE +: WORD_SIZE];
      assign data_arr[g] = req_data[g*WORD_SIZE +: WORD_SIZE];
   end

   // Search upward from last_grant+1 with wrap so every requester gets a turn within NUM_REQ slots.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = last_grant;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == LAST_ID) ? '0 : cand + ID_ONE;
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   assign req_ready = (rst_n && (phase == PH_OP) && gnt_found) ?
                      (NUM_REQ'(1) << gnt_id) : '0;
   assign accept    = |(req_valid & req_ready);

   assign l1_wr_en = iss_valid & iss_wr;
   assign l1_addr  = iss_valid ? iss_addr : '0;
   assign l1_data  = iss_valid ? iss_data : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase      <= PH_ADDR;
         last_grant <= LAST_ID;
         iss_valid  <= 1'b0;
         iss_wr     <= 1'b0;
         iss_addr   <= '0;
         iss_data   <= '0;
         iss_id     <= '0;
         pend       <= 1'b0;
         pend_wr    <= 1'b0;
         pend_id    <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_wr     <= 1'b0;
         rsp_hit    <= 1'b0;
         rsp_data   <= '0;
      end else begin
         phase <= ~phase;

         if (accept) begin
            iss_valid  <= 1'b1;
            iss_wr     <= req_wr[gnt_id];
            iss_addr   <= addr_arr[gnt_id];
            iss_data   <= data_arr[gnt_id];
            iss_id     <= gnt_id;
            last_grant <= gnt_id;
         end else if (phase == PH_OP) begin
            iss_valid <= 1'b0;
         end

         // The slot finishing its OP here hands off to the response stage, even when a new one is accepted.
         if (phase == PH_OP) begin
            pend    <= iss_valid;
            pend_wr <= iss_wr;
            pend_id <= iss_id;
         end else begin
            pend <= 1'b0;
         end

         rsp_valid <= (phase == PH_ADDR) && pend;
         if ((phase == PH_ADDR) && pend) begin
            rsp_id   <= pend_id;
            rsp_wr   <= pend_wr;
            rsp_hit  <= l1_hit;
            rsp_data <= l1_data_out;
         end
      end
   end

`ifdef L1_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_rd_hits   <= '0;
         stat_rd_misses <= '0;
      end else if (rsp_valid && !rsp_wr) begin
         if (rsp_hit && (stat_rd_hits != 16'hFFFF)) begin
            stat_rd_hits <= stat_rd_hits + 16'd1;
         end
         if (!rsp_hit && (stat_rd_misses != 16'hFFFF)) begin
            stat_rd_misses <= stat_rd_misses + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_l1_arbiter.sv
// Testbench for l1_arbiter: behavioural two-phase l1 model, table-driven vectors, reset/round-robin
// sequences and a randomized phase checked every cycle against a transaction-level reference model.
module tb_l1_arbiter;
   localparam int NR  = 2;
   localparam int WS  = 32;
   localparam int IDW = 1;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_wr;
   logic [NR*WS-1:0]  req_addr;
   logic [NR*WS-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              l1_wr_en;
   logic [WS-1:0]     l1_addr;
   logic [WS-1:0]     l1_data;
   logic [WS-1:0]     l1_data_out;
   logic              l1_hit;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_wr;
   logic              rsp_hit;
   logic [WS-1:0]     rsp_data;
`ifdef L1_ARB_STATS_EN
   logic [15:0]       stat_rd_hits;
   logic [15:0]       stat_rd_misses;
`endif

   logic [WS-1:0]     a_arr [NR];
   logic [WS-1:0]     d_arr [NR];

   for (genvar g = 0; g < NR; g++) begin : g_pack
      assign req_addr[g*WS +: WS] = a_arr[g];
      assign req_data[g*WS +: WS] = d_arr[g];
   end

   l1_arbiter #(.NUM_REQ(NR), .WORD_SIZE(WS), .ID_W(IDW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .l1_wr_en    (l1_wr_en),
      .l1_addr     (l1_addr),
      .l1_data     (l1_data),
      .l1_data_out (l1_data_out),
      .l1_hit      (l1_hit),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_wr      (rsp_wr),
      .rsp_hit     (rsp_hit),
      .rsp_data    (rsp_data)
`ifdef L1_ARB_STATS_EN
      ,
      .stat_rd_hits   (stat_rd_hits),
      .stat_rd_misses (stat_rd_misses)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-phase direct-mapped l1: one word per line, index addr[7:2], tag addr[31:8].
   logic          l1_ph;
   logic [WS-1:0] l1_lat;
   logic          l1_v   [64];
   logic [23:0]   l1_tag [64];
   logic [WS-1:0] l1_mem [64];

   always @(posedge clk) begin
      if (!rst_n) begin
         l1_ph       <= 1'b0;
         l1_hit      <= 1'b0;
         l1_data_out <= '0;
         for (int i = 0; i < 64; i++) l1_v[i] <= 1'b0;
      end else begin
         l1_ph <= ~l1_ph;
         if (!l1_ph) begin
            l1_lat <= l1_addr;
         end else if (l1_wr_en) begin
            l1_v[l1_lat[7:2]]   <= 1'b1;
            l1_tag[l1_lat[7:2]] <= l1_lat[31:8];
            l1_mem[l1_lat[7:2]] <= l1_data;
            l1_hit              <= 1'b1;
            l1_data_out         <= l1_data;
         end else if (l1_v[l1_lat[7:2]] && (l1_tag[l1_lat[7:2]] == l1_lat[31:8])) begin
            l1_hit      <= 1'b1;
            l1_data_out <= l1_mem[l1_lat[7:2]];
         end else begin
            l1_hit      <= 1'b0;
            l1_data_out <= '0;
         end
      end
   end

   typedef struct {
      logic [IDW-1:0] id;
      logic           wr;
      logic [WS-1:0]  addr;
      logic [WS-1:0]  data;
      logic           exp_hit;
      logic [WS-1:0]  exp_data;
   } vec_t;

   typedef struct {
      int             due;
      logic [IDW-1:0] id;
      logic           wr;
      logic           hit;
      logic [WS-1:0]  data;
   } rsp_t;

   int            n_chk = 0;
   int            n_err = 0;
   int            ecnt = 0;
   bit            exp_phase = 1'b0;
   int            ref_last = NR - 1;
   int            ref_hits = 0;
   int            ref_misses = 0;
   rsp_t          exp_q [$];
   int            gnt_log [$];
   logic [23:0]   line_tag [int];
   logic [WS-1:0] line_data [int];
   logic [NR-1:0] last_acc;
   logic          seen_rsp;
   logic [IDW-1:0] cap_id;
   logic          cap_wr;
   logic          cap_hit;
   logic [WS-1:0] cap_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle reference: round-robin grant from the valid set, expected response 4 cycles later.
   task automatic monitor();
      int            g;
      int            c;
      int            idx;
      logic [NR-1:0] exp_rdy;
      logic [WS-1:0] a;
      rsp_t          e;
      last_acc = '0;
      seen_rsp = 1'b0;
      if (!rst_n) begin
         exp_q.delete();
         line_tag.delete();
         line_data.delete();
         ref_last   = NR - 1;
         ref_hits   = 0;
         ref_misses = 0;
         chk("ready_in_reset", 32'(req_ready), 0);
      end else begin
`ifdef L1_ARB_STATS_EN
         chk("stat_rd_hits", 32'(stat_rd_hits), ref_hits);
         chk("stat_rd_misses", 32'(stat_rd_misses), ref_misses);
`endif
         if (rsp_valid) begin
            seen_rsp = 1'b1;
            cap_id   = rsp_id;
            cap_wr   = rsp_wr;
            cap_hit  = rsp_hit;
            cap_data = rsp_data;
         end
         if (exp_q.size() > 0 && exp_q[0].due == ecnt) begin
            e = exp_q.pop_front();
            chk("mon_rsp_valid", 32'(rsp_valid), 1);
            chk("mon_rsp_id", 32'(rsp_id), 32'(e.id));
            chk("mon_rsp_wr", 32'(rsp_wr), 32'(e.wr));
            chk("mon_rsp_hit", 32'(rsp_hit), 32'(e.hit));
            chk("mon_rsp_data", rsp_data, e.data);
            if (!e.wr && e.hit && ref_hits < 65535) ref_hits++;
            if (!e.wr && !e.hit && ref_misses < 65535) ref_misses++;
         end else begin
            chk("mon_rsp_idle", 32'(rsp_valid), 0);
         end
         g = -1;
         if (exp_phase) begin
            for (int k = 1; k <= NR; k++) begin
               c = (ref_last + k) % NR;
               if (g < 0 && req_valid[IDW'(c)]) g = c;
            end
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[IDW'(g)] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         last_acc = req_valid & req_ready;
         if (g >= 0) begin
            ref_last = g;
            gnt_log.push_back(g);
            a     = a_arr[IDW'(g)];
            idx   = int'(a[7:2]);
            e.due = ecnt + 4;
            e.id  = IDW'(g);
            e.wr  = req_wr[IDW'(g)];
            if (e.wr) begin
               line_tag[idx]  = a[31:8];
               line_data[idx] = d_arr[IDW'(g)];
               e.hit  = 1'b1;
               e.data = d_arr[IDW'(g)];
            end else if (line_tag.exists(idx) && line_tag[idx] == a[31:8]) begin
               e.hit  = 1'b1;
               e.data = line_data[idx];
            end else begin
               e.hit  = 1'b0;
               e.data = '0;
            end
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      if (rst_n) begin
         ecnt++;
         exp_phase = ~exp_phase;
      end else begin
         ecnt      = 0;
         exp_phase = 1'b0;
      end
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
      chk({tag, "_rsp_wr"}, 32'(rsp_wr), 0);
      chk({tag, "_rsp_hit"}, 32'(rsp_hit), 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_l1_wr_en"}, 32'(l1_wr_en), 0);
      chk({tag, "_l1_addr"}, l1_addr, 0);
      chk({tag, "_l1_data"}, l1_data, 0);
      chk({tag, "_req_ready"}, 32'(req_ready), 0);
`ifdef L1_ARB_STATS_EN
      chk({tag, "_stat_hits"}, 32'(stat_rd_hits), 0);
      chk({tag, "_stat_misses"}, 32'(stat_rd_misses), 0);
`endif
   endtask

   task automatic issue_one(input vec_t v);
      logic acc;
      logic got;
      int   n;
      req_valid       = '0;
      req_valid[v.id] = 1'b1;
      req_wr[v.id]    = v.wr;
      a_arr[v.id]     = v.addr;
      d_arr[v.id]     = v.data;
      acc = 1'b0;
      for (int t = 0; t < 6 && !acc; t++) begin
         tick();
         acc = last_acc[v.id];
      end
      chk("vec_accept", 32'(acc), 1);
      req_valid = '0;
      got = 1'b0;
      n   = 0;
      for (int t = 0; t < 8 && !got; t++) begin
         tick();
         n++;
         got = seen_rsp;
      end
      chk("vec_latency", n, 4);
      chk("vec_rsp_id", 32'(cap_id), 32'(v.id));
      chk("vec_rsp_wr", 32'(cap_wr), 32'(v.wr));
      chk("vec_rsp_hit", 32'(cap_hit), 32'(v.exp_hit));
      chk("vec_rsp_data", cap_data, v.exp_data);
   endtask

   vec_t vecs [7];

   initial begin
      logic acc;
      vecs[0] = '{id: 1'd0, wr: 1'b0, addr: 32'h0000_0010, data: 32'h0,         exp_hit: 1'b0, exp_data: 32'h0};
      vecs[1] = '{id: 1'd1, wr: 1'b1, addr: 32'h0000_0020, data: 32'hDEAD_BEEF, exp_hit: 1'b1, exp_data: 32'hDEAD_BEEF};
      vecs[2] = '{id: 1'd1, wr: 1'b0, addr: 32'h0000_0020, data: 32'h0,         exp_hit: 1'b1, exp_data: 32'hDEAD_BEEF};
      vecs[3] = '{id: 1'd0, wr: 1'b1, addr: 32'h0000_0030, data: 32'h1111_1111, exp_hit: 1'b1, exp_data: 32'h1111_1111};
      vecs[4] = '{id: 1'd1, wr: 1'b0, addr: 32'h1000_0030, data: 32'h0,         exp_hit: 1'b0, exp_data: 32'h0};
      vecs[5] = '{id: 1'd0, wr: 1'b0, addr: 32'h0000_0030, data: 32'h0,         exp_hit: 1'b1, exp_data: 32'h1111_1111};
      vecs[6] = '{id: 1'd0, wr: 1'b0, addr: 32'h0000_0020, data: 32'h0,         exp_hit: 1'b1, exp_data: 32'hDEAD_BEEF};

      rst_n     = 1'b0;
      req_valid = '0;
      req_wr    = '0;
      for (int i = 0; i < NR; i++) begin
         a_arr[IDW'(i)] = '0;
         d_arr[IDW'(i)] = '0;
      end
      for (int t = 0; t < 3; t++) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) issue_one(vecs[i]);
`ifdef L1_ARB_STATS_EN
      tick();
      chk("stats_hits_3", 32'(stat_rd_hits), 3);
      chk("stats_misses_2", 32'(stat_rd_misses), 2);
`endif

      // Reset during the OP cycle of a write: no response, everything back to zero.
      req_valid    = 2'b01;
      req_wr[0]    = 1'b1;
      a_arr[0]     = 32'h0000_0040;
      d_arr[0]     = 32'h5555_AAAA;
      acc = 1'b0;
      for (int t = 0; t < 6 && !acc; t++) begin
         tick();
         acc = last_acc[0];
      end
      chk("midop_accept", 32'(acc), 1);
      req_valid = '0;
      chk("addr_l1_addr", l1_addr, 32'h0000_0040);
      chk("addr_l1_data", l1_data, 32'h5555_AAAA);
      chk("addr_l1_wr_en", 32'(l1_wr_en), 1);
      tick();
      chk("op_l1_wr_en", 32'(l1_wr_en), 1);
      rst_n = 1'b0;
      tick();
      check_all_zero("midop");
      rst_n = 1'b1;
      for (int t = 0; t < 8; t++) tick();

      // Both requesters hold valid for six slots.
      req_valid = 2'b11;
      req_wr    = 2'b00;
      a_arr[0]  = 32'h0000_0050;
      a_arr[1]  = 32'h0000_0060;
      gnt_log.delete();
      for (int t = 0; t < 40 && gnt_log.size() < 6; t++) tick();
      req_valid = '0;
      chk("rr_count", gnt_log.size(), 6);
      for (int k = 0; k < 6; k++) begin
         chk("rr_grant", (k < gnt_log.size()) ? gnt_log[k] : -1, k % 2);
      end
      for (int t = 0; t < 8; t++) tick();

      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < NR; i++) begin
            req_valid[IDW'(i)] = ($urandom_range(0, 9) < 6);
            req_wr[IDW'(i)]    = ($urandom_range(0, 2) == 0);
            a_arr[IDW'(i)]     = (($urandom_range(0, 1) == 1) ? 32'h1000_0000 : 32'h0) |
                                 (32'($urandom_range(0, 3)) << 2);
            d_arr[IDW'(i)]     = $urandom();
         end
         tick();
      end
      req_valid = '0;
      for (int t = 0; t < 8; t++) tick();
      chk("drain_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
